toggle_event_decoder: RTL and testbench

//  Receive end of a toggle-encoded event line: each level change on tog_in is one event.
//  - Synchronises the asynchronous tog_in into clk and detects changes.
//  - Emits a one-cycle pulse per event and queues events in a saturating pending counter.
//  - Drains the queue through a valid/ready handshake.
//  - Consumes the line driven by the toggle flip-flops elsewhere in the design.

---
 rtl/tog_dec_pkg.sv | 15 +
 rtl/tog_sync.sv | 25 ++
 rtl/toggle_event_decoder.sv | 137 +++++++++++++
 tb/tb_toggle_event_decoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/tog_dec_pkg.sv
// Shared types and helpers for the toggle event decoder.
package tog_dec_pkg;

    typedef enum logic [0:0] {
        PRIME,
        RUN
    } state_e;

    localparam int unsigned SYNC_MIN = 2;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/tog_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, async reset to 0.
module tog_sync
    import tog_dec_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Toggle-line event receiver: synchronise, detect level changes, queue events with a
// valid/ready drain. Define TOG_DEC_GLITCH_FILTER_EN to require a 2-cycle stable level.
module toggle_event_decoder
    import tog_dec_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    output logic             evt_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_pending,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

    logic sync_lvl;
    logic cmp_level;

    state_e           state_q, state_d;
    logic [2:0]       prime_cnt_q, prime_cnt_d;
    logic             ref_q, ref_d;
    logic             evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             hs;

    tog_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (tog_in),
        .q  (sync_lvl)
    );

`ifdef TOG_DEC_GLITCH_FILTER_EN
    localparam int unsigned FiltStages = 1;

    logic sync_d1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_d1_q <= 1'b0;
        end else begin
            sync_d1_q <= sync_lvl;
        end
    end

    // A level seen for only one cycle keeps the old reference, so it never compares.
    assign cmp_level = (sync_lvl == sync_d1_q) ? sync_lvl : ref_q;
`else
    localparam int unsigned FiltStages = 0;

    assign cmp_level = sync_lvl;
`endif

    // Stay primed until the reset-time zeros have left the synchroniser (and filter), so a
    // line held high through reset is absorbed into the reference instead of firing.
    localparam int unsigned PrimeLast = SYNC_STAGES + FiltStages;

    assign hs = valid_q && evt_ready;

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        ref_d       = ref_q;
        evt_d       = 1'b0;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            PRIME: begin
                ref_d       = cmp_level;
                prime_cnt_d = prime_cnt_q + 3'd1;
                if (prime_cnt_q == 3'(PrimeLast)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cmp_level != ref_q) begin
                    evt_d = 1'b1;
                    ref_d = cmp_level;
                end
            end
            default: state_d = PRIME;
        endcase

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        if (evt_d && !hs) begin
            if (cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!evt_d && hs) begin
            cnt_d = cnt_q - 1'b1;
        end

        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PRIME;
            prime_cnt_q <= '0;
            ref_q       <= 1'b0;
            evt_q       <= 1'b0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            ref_q       <= ref_d;
            evt_q       <= evt_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_pulse   = evt_q;
    assign evt_valid   = valid_q;
    assign evt_pending = cnt_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder: priming, latency, drain, overflow, reset.
module tb_toggle_event_decoder;

    localparam int unsigned S = 2;
    localparam int unsigned W = 4;
`ifdef TOG_DEC_GLITCH_FILTER_EN
    localparam int unsigned LAT = S + 2;
`else
    localparam int unsigned LAT = S + 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tog_in = 1'b1;
    logic         evt_pulse;
    logic         evt_valid;
    logic         evt_ready = 1'b0;
    logic [W-1:0] evt_pending;
    logic         ovf;
    logic         ovf_clr = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    toggle_event_decoder #(
        .SYNC_STAGES(S),
        .CNT_W      (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tog_in     (tog_in),
        .evt_pulse  (evt_pulse),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_pending(evt_pending),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flip the line mid-cycle, expect exactly one pulse LAT edges later.
    task automatic toggle_and_check(input string tag);
        @(negedge clk);
        tog_in = ~tog_in;
        for (int k = 1; k <= int'(LAT); k++) begin
            tick();
            check(tag, 32'(evt_pulse), 32'(k == int'(LAT)));
        end
        tick();
        check({tag, "_one_cycle"}, 32'(evt_pulse), 32'd0);
    endtask

    initial begin
        // Test 1: line high through reset never fires
        repeat (3) @(negedge clk);
        #1;
        check("rst_pending", 32'(evt_pending), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("prime_no_pulse", 32'(evt_pulse), 32'd0);
            check("prime_pending", 32'(evt_pending), 32'd0);
        end

        // Test 2: three toggles queue three events
        for (int i = 0; i < 3; i++) begin
            toggle_and_check("t2_pulse");
            check("t2_pending", 32'(evt_pending), 32'(i + 1));
            repeat (2) tick();
        end
        check("t2_valid", 32'(evt_valid), 32'd1);

        // Test 3: drain, then extra ready cycles must not underflow
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            evt_ready = 1'b1;
            tick();
            check("t3_pending", 32'(evt_pending), (i < 3) ? 32'(2 - i) : 32'd0);
            check("t3_valid", 32'(evt_valid), (i < 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        evt_ready = 1'b0;

        // Test 4: sixteen toggles saturate at 15 and set ovf
        for (int i = 0; i < 16; i++) begin
            toggle_and_check("t4_pulse");
            check("t4_pending", 32'(evt_pending), (i < 15) ? 32'(i + 1) : 32'd15);
            check("t4_ovf", 32'(ovf), (i == 15) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        ovf_clr = 1'b1;
        tick();
        check("t4_ovf_clr", 32'(ovf), 32'd0);
        check("t4_pending_hold", 32'(evt_pending), 32'd15);
        @(negedge clk);
        ovf_clr = 1'b0;

        // Test 5: event and handshake together while full
        @(negedge clk);
        tog_in = ~tog_in;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        evt_ready = 1'b1;
        tick();
        check("t5_pulse", 32'(evt_pulse), 32'd1);
        check("t5_pending", 32'(evt_pending), 32'd15);
        check("t5_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        evt_ready = 1'b0;
        tick();
        check("t5_valid", 32'(evt_valid), 32'd1);

        // Test 6: drop coinciding with ovf_clr keeps ovf set
        @(negedge clk);
        tog_in = ~tog_in;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        ovf_clr = 1'b1;
        tick();
        check("t6_pulse", 32'(evt_pulse), 32'd1);
        check("t6_ovf_set_wins", 32'(ovf), 32'd1);
        check("t6_pending", 32'(evt_pending), 32'd15);
        @(negedge clk);
        ovf_clr = 1'b0;

`ifdef TOG_DEC_GLITCH_FILTER_EN
        // Test 7: single-cycle glitch is filtered
        @(negedge clk);
        tog_in = ~tog_in;
        @(negedge clk);
        tog_in = ~tog_in;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t7_glitch_no_pulse", 32'(evt_pulse), 32'd0);
        end
        toggle_and_check("t7_held_pulse");
`endif

        // Test 8: reset mid-operation discards queue and ovf
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t8_pending", 32'(evt_pending), 32'd0);
        check("t8_ovf", 32'(ovf), 32'd0);
        check("t8_valid", 32'(evt_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t8_no_pulse", 32'(evt_pulse), 32'd0);
        end
        toggle_and_check("t8_pulse");
        check("t8_pending_after", 32'(evt_pending), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
